// File: rtl/divider_reconstruct_mae.sv
// Reconstructs n' = q*d + r with a DW-cycle shift-add multiplier and reports |n - n'|,
// keeping saturating running sum, maximum and count of the errors.
module divider_reconstruct_mae #(
    parameter int unsigned NW   = 16,
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NW-1:0]   n,
    input  logic [DW-1:0]   d,
    input  logic [DW-1:0]   q,
    input  logic [DW-1:0]   r,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NW:0]     recon,
    output logic [NW:0]     abs_err,
    output logic            skipped,
    output logic [ACCW-1:0] err_sum,
    output logic [NW:0]     err_max,
    output logic [CNTW-1:0] sample_cnt
);
    localparam int unsigned RW = NW + 1;
    localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;
    // Wide enough that err_sum + abs_err never wraps, whichever of the two is wider.
    localparam int unsigned SW = ((ACCW > RW) ? ACCW : RW) + 1;

    typedef enum logic [1:0] {StIdle, StMul, StFin, StHold} state_e;

    state_e        state_q, state_d;
    logic [NW-1:0] n_q;
    logic [DW-1:0] d_q, q_q, r_q;
    logic [RW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] n_ext, recon_d, abs_err_d;
    logic [SW-1:0] sum_wide;
    logic          accept, fin_update;

    assign accept     = in_valid & in_ready;
    assign n_ext      = {1'b0, n_q};
    assign recon_d    = acc_q + RW'(r_q);
    assign abs_err_d  = (n_ext >= recon_d) ? (n_ext - recon_d) : (recon_d - n_ext);
    assign sum_wide   = SW'(err_sum) + SW'(abs_err_d);
    assign fin_update = (state_q == StFin) && (d_q != '0);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StMul;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            StMul: begin
                if (q_q[idx_q]) begin
                    acc_d = acc_q + (RW'(d_q) << idx_q);
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(DW - 1)) begin
                    state_d = StFin;
                end
            end
            StFin: state_d = StHold;
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            acc_q      <= '0;
            idx_q      <= '0;
            n_q        <= '0;
            d_q        <= '0;
            q_q        <= '0;
            r_q        <= '0;
            recon      <= '0;
            abs_err    <= '0;
            skipped    <= 1'b0;
            err_sum    <= '0;
            err_max    <= '0;
            sample_cnt <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            // Handshake flags are decoded from the next state so they come straight off flops.
            in_ready  <= (state_d == StIdle);
            out_valid <= (state_d == StHold);
            if (accept) begin
                n_q <= n;
                d_q <= d;
                q_q <= q;
                r_q <= r;
            end
            if (state_q == StFin) begin
                recon   <= recon_d;
                abs_err <= abs_err_d;
                skipped <= (d_q == '0);
            end
            if (clear) begin
                err_sum    <= '0;
                err_max    <= '0;
                sample_cnt <= '0;
            end else if (fin_update) begin
                err_sum    <= (sum_wide > SW'({ACCW{1'b1}})) ? '1 : sum_wide[ACCW-1:0];
                err_max    <= (abs_err_d > err_max) ? abs_err_d : err_max;
                sample_cnt <= (&sample_cnt) ? sample_cnt : sample_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_reconstruct_mae.sv
// Scoreboard bench for divider_reconstruct_mae; a second instance with an 8-bit sum
// accumulator runs in lockstep to exercise saturation.
module tb_divider_reconstruct_mae;
    localparam int unsigned NW   = 16;
    localparam int unsigned DW   = 8;
    localparam int unsigned ACCW = 32;
    localparam int unsigned CNTW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [NW-1:0] n = '0;
    logic [DW-1:0] d = '0;
    logic [DW-1:0] q = '0;
    logic [DW-1:0] r = '0;

    logic            in_ready, out_valid, skipped;
    logic [NW:0]     recon, abs_err, err_max;
    logic [ACCW-1:0] err_sum;
    logic [CNTW-1:0] sample_cnt;

    logic            in_ready8, out_valid8, skipped8;
    logic [NW:0]     recon8, abs_err8, err_max8;
    logic [7:0]      err_sum8;
    logic [CNTW-1:0] sample_cnt8;

    divider_reconstruct_mae #(.NW(NW), .DW(DW), .ACCW(ACCW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .n(n), .d(d), .q(q), .r(r), .out_valid(out_valid), .out_ready(out_ready),
        .recon(recon), .abs_err(abs_err), .skipped(skipped), .err_sum(err_sum),
        .err_max(err_max), .sample_cnt(sample_cnt)
    );

    divider_reconstruct_mae #(.NW(NW), .DW(DW), .ACCW(8), .CNTW(CNTW)) dut8 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
        .n(n), .d(d), .q(q), .r(r), .out_valid(out_valid8), .out_ready(out_ready),
        .recon(recon8), .abs_err(abs_err8), .skipped(skipped8), .err_sum(err_sum8),
        .err_max(err_max8), .sample_cnt(sample_cnt8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW:0]     recon;
        logic [NW:0]     abs_err;
        logic            skipped;
        logic [ACCW-1:0] sum;
        logic [NW:0]     max;
        logic [CNTW-1:0] cnt;
        logic [7:0]      sum8;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [NW:0] rc, input logic [NW:0] ab, input logic sk,
                                input logic [ACCW-1:0] s, input logic [NW:0] m,
                                input logic [CNTW-1:0] c, input logic [7:0] s8);
        exp_t e;
        e.recon = rc; e.abs_err = ab; e.skipped = sk;
        e.sum = s; e.max = m; e.cnt = c; e.sum8 = s8;
        return e;
    endfunction

    // Monitor: every output handshake pops one expectation.
    exp_t me;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got recon 0x%0h, expected no output", recon);
            end else begin
                me = sb.pop_front();
                n_seen++;
                chk("recon", recon, me.recon);
                chk("abs_err", abs_err, me.abs_err);
                chk("skipped", skipped, me.skipped);
                chk("err_sum", err_sum, me.sum);
                chk("err_max", err_max, me.max);
                chk("sample_cnt", sample_cnt, me.cnt);
                chk("err_sum_sat8", err_sum8, me.sum8);
            end
        end
    end

    task automatic send(input logic [NW-1:0] tn, input logic [DW-1:0] td, input logic [DW-1:0] tq,
                        input logic [DW-1:0] tr, input exp_t e, input bit push);
        int c = 0;
        while (!in_ready && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        chk("in_ready_wait", in_ready, 1);
        n = tn; d = td; q = tq; r = tr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) sb.push_back(e);
        // Scramble the inputs: the block must work from its captured copy.
        n = ~tn; d = ~td; q = ~tq; r = ~tr;
    endtask

    task automatic wait_valid(input int exp_c, input string name);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!out_valid && c < 40);
        chk(name, c, exp_c);
    endtask

    task automatic finish_out();
        @(posedge clk); #1;
        chk("in_ready_after_handshake", in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_valid;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_recon", recon, 0);
        chk("rst_abs_err", abs_err, 0);
        chk("rst_skipped", skipped, 0);
        chk("rst_err_sum", err_sum, 0);
        chk("rst_err_max", err_max, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", in_ready, 1);

        // Exact sample, with latency check
        send(16'd1000, 8'd10, 8'd100, 8'd0, mk(1000, 0, 0, 0, 0, 1, 0), 1);
        chk("in_ready_busy", in_ready, 0);
        wait_valid(10, "latency_exact");
        finish_out();

        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_err_sum", err_sum, 0);
        chk("clear_sample_cnt", sample_cnt, 0);
        @(posedge clk); #1;

        // Approximate samples
        send(16'd1000, 8'd10, 8'd99, 8'd5, mk(995, 5, 0, 5, 5, 1, 5), 1);
        wait_valid(10, "latency_approx1");
        finish_out();
        send(16'd10, 8'd3, 8'd4, 8'd0, mk(12, 2, 0, 7, 5, 2, 7), 1);
        wait_valid(10, "latency_approx2");
        finish_out();

        // Extremes; the 8-bit accumulator saturates here
        send(16'hFFFF, 8'hFF, 8'hFF, 8'hFF, mk(65280, 255, 0, 262, 255, 3, 255), 1);
        wait_valid(10, "latency_extreme");
        finish_out();

        // Divide by zero is excluded from statistics
        send(16'h0100, 8'h00, 8'h12, 8'h34, mk(17'h34, 17'hCC, 1, 262, 255, 3, 255), 1);
        wait_valid(10, "latency_div0");
        finish_out();

        // Backpressure
        out_ready = 1'b0;
        send(16'd21, 8'd2, 8'd10, 8'd0, mk(20, 1, 0, 263, 255, 4, 255), 1);
        wait_valid(10, "latency_bp");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_recon", recon, 20);
            chk("bp_abs_err", abs_err, 1);
            chk("bp_err_sum", err_sum, 263);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        finish_out();

        // Clear coinciding with the FIN edge wins over the update
        send(16'd100, 8'd10, 8'd9, 8'd1, mk(91, 9, 0, 0, 0, 0, 0), 1);
        repeat (8) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        wait_valid(1, "latency_clear_fin");
        finish_out();

        // Reset in the middle of MUL aborts the sample
        send(16'd500, 8'd5, 8'd100, 8'd0, mk(0, 0, 0, 0, 0, 0, 0), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_recon", recon, 0);
        chk("midrst_abs_err", abs_err, 0);
        chk("midrst_skipped", skipped, 0);
        chk("midrst_err_sum", err_sum, 0);
        chk("midrst_err_max", err_max, 0);
        chk("midrst_sample_cnt", sample_cnt, 0);
        chk("midrst_err_sum8", err_sum8, 0);
        @(posedge clk); #1;
        chk("midrst_in_ready", in_ready, 1);
        seen_valid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midrst_no_output", seen_valid, 0);

        chk("scoreboard_empty", sb.size(), 0);
        chk("outputs_seen", n_seen, 7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_reconstruct_mae.md
# divider_reconstruct_mae

Sequential error monitor for the 16/8 array dividers. For each sample (n, d, q, r) it reconstructs n' = q*d + r using an 8-cycle shift-add multiplier and reports |n − n'|. It also accumulates the running sum, maximum and count of errors, so the MAE of an approximate divider variant is measured in simulation or on FPGA. It sits downstream of a divider instance and consumes the divider's inputs and outputs together.

## Interface
- NW, 16, dividend width
- DW, 8, divisor/quotient/remainder width
- ACCW, 32, error-sum accumulator width
- CNTW, 16, sample-counter width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous clear of statistics only
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample
- n  in  NW  dividend fed to the divider
- d  in  DW  divisor
- q  in  DW  divider quotient
- r  in  DW  divider remainder
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- recon  out  NW+1  q*d + r
- abs_err  out  NW+1  |n − recon|
- skipped  out  1  sample excluded from statistics (d == 0)
- err_sum  out  ACCW  saturating sum of abs_err
- err_max  out  NW+1  largest abs_err seen
- sample_cnt  out  CNTW  saturating count of included samples

## Operation
- FSM states: IDLE, MUL, FIN, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register n, d, q, r, clear acc (NW+1 bits) and bit index i = 0, then go to MUL.
- MUL, 8 cycles (i = 0..7, LSB first):
  - If q[i] = 1, acc += {d, i zeros}.
  - i increments each cycle; after i = 7, go to FIN.
- FIN, 1 cycle:
  - recon ← acc + r, computed in NW+1 bits; this cannot overflow, because the maximum is 255*255 + 255 = 65280.
  - abs_err ← (n ≥ recon) ? n − recon : recon − n, with n zero-extended.
  - skipped ← (d == 0).
  - If not skipped, update statistics on this edge:
    - err_sum += abs_err, saturating at all ones.
    - err_max = max(err_max, abs_err).
    - sample_cnt += 1, saturating.
  - Go to HOLD.
- HOLD:
  - out_valid = 1; recon, abs_err and skipped stay stable.
  - On out_valid & out_ready, go to IDLE.
- clear:
  - Zeroes err_sum, err_max and sample_cnt on the next edge, in any state.
  - If clear coincides with a FIN statistics update, clear wins and that sample is not counted.
  - Does not affect the FSM, recon, abs_err or skipped.
- Inputs n/d/q/r are sampled only on the accept edge. Changes afterwards are ignored.

## Timing
- Reset values:
  - State IDLE.
  - in_ready = 0 while rst is high; 1 in the first cycle after rst is released.
  - out_valid = 0; recon, abs_err, skipped, err_sum, err_max and sample_cnt are all 0.
- rst mid-operation (MUL/FIN/HOLD) aborts the sample. The result is never presented and statistics are cleared.
- Latency:
  - Accept edge at cycle 0; MUL occupies cycles 1–8; FIN is cycle 9.
  - out_valid is high from cycle 10.
  - Statistics outputs reflect the sample from cycle 10.
- Throughput:
  - in_ready is low from the cycle after accept until the cycle after the out handshake.
  - There is no bypass, so the minimum sample period is 11 cycles.
- out_ready held low holds HOLD indefinitely with outputs stable. out_ready high while out_valid is low has no effect.
- in_valid while in_ready is low is ignored; the source must hold the sample.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Exact sample: n=1000, d=10, q=100, r=0 → out_valid at cycle 10.
  - Expect recon=1000, abs_err=0, sample_cnt=1, err_sum=0.
- Approximate sample: n=1000, d=10, q=99, r=5 → recon=995, abs_err=5. Follow with n=10, d=3, q=4, r=0 → recon=12, abs_err=2.
  - After both: err_sum=7, err_max=5, sample_cnt=2.
- Extremes: n=0xFFFF, d=0xFF, q=0xFF, r=0xFF → recon=65280, abs_err=255, err_max=255.
- Divide by zero: d=0, q=0x12, r=0x34 → recon=0x34, skipped=1, statistics unchanged.
- Backpressure and clear:
  - Hold out_ready=0 for 20 cycles → outputs stable and in_ready=0; release → in_ready=1 on the next cycle.
  - Assert clear on the FIN edge of a sample with abs_err=9 → err_sum=0, sample_cnt=0.
- Reset mid-MUL: assert rst at cycle 4 → out_valid never rises, all outputs 0, and in_ready=1 one cycle after release.
  - Saturation: force err_sum near 2^ACCW−1 (reduced ACCW=8 build) → err_sum sticks at 0xFF.
